// File: rtl/spmv_pkg.sv
// Shared definitions for the CSR sparse-matrix x dense-vector core.
//   - load_sel encodings for the four internal memories
//   - run-control state enum
//   - default width constants and a small width helper
package spmv_pkg;

  localparam logic [1:0] SEL_VAL = 2'd0;
  localparam logic [1:0] SEL_COL = 2'd1;
  localparam logic [1:0] SEL_PTR = 2'd2;
  localparam logic [1:0] SEL_X   = 2'd3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 64;
  localparam int DEF_NNZ_AW = 10;
  localparam int DEF_ROW_AW = 10;
  localparam int DEF_COL_AW = 10;

  typedef enum logic [2:0] {
    IDLE,
    PTR,
    WALK,
    EMIT,
    FIN
  } spmv_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spmv_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// registered read data (1-cycle latency). Contents are never cleared.
//   clk   : clock
//   we    : write enable
//   waddr : write address (writes beyond DEPTH are dropped)
//   wdata : write data
//   raddr : read address (reads beyond DEPTH return 0)
//   rdata : read data, valid the cycle after raddr is presented
module spmv_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The row-pointer memory has a non power-of-two depth, so addresses
  // are range-checked rather than silently aliased.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
    rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
  end

endmodule

// File: rtl/csr_spmv_core.sv
// CSR sparse-matrix x dense-vector engine: y = A * x.
// Four internal memories (value, column, row pointer, x) are filled through
// one handshaked load port while idle. After start, rows are walked one at a
// time and each row's dot product is emitted on a valid/ready stream.
//   clk, reset       : clock, asynchronous active-low reset
//   load_valid/ready : load handshake (ready only while idle)
//   load_sel         : target memory (SEL_VAL/SEL_COL/SEL_PTR/SEL_X)
//   load_addr/data   : write address / data (low bits used per target)
//   start, n_rows    : begin a run of n_rows rows (n_rows sampled on start)
//   busy, done       : run in progress / one-cycle completion pulse
//   out_valid/ready  : result handshake
//   out_row          : row index of the result
//   out_data         : signed row dot product (two's complement wrap)
//   out_zero         : row had no non-zeros
module csr_spmv_core
  import spmv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NNZ_AW = DEF_NNZ_AW,
  parameter int ROW_AW = DEF_ROW_AW,
  parameter int COL_AW = DEF_COL_AW,
  localparam int LOAD_AW = max3(NNZ_AW, ROW_AW + 1, COL_AW)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [1:0]               load_sel,
  input  logic [LOAD_AW-1:0]       load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     start,
  input  logic [ROW_AW:0]          n_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_AW-1:0]        out_row,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_zero
);

  localparam int PTR_DEPTH = (1 << ROW_AW) + 1;
  localparam logic [ROW_AW:0] ONE_R = (ROW_AW + 1)'(1);
  localparam logic [NNZ_AW:0] ONE_P = (NNZ_AW + 1)'(1);

  function automatic logic signed [ACC_W-1:0] mul_sext(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
    prod = a * b;
    return ACC_W'(prod);
  endfunction

  // Plain two's complement wrap, no saturation.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    return a + b;
  endfunction

  spmv_state_t state, state_nxt;

  logic                     ph;        // PTR sub-phase: 0 = rowptr[r], 1 = rowptr[r+1]
  logic [ROW_AW:0]          r;
  logic [ROW_AW:0]          n_rows_q;
  // Pointers keep one extra bit so a row ending exactly at the memory depth
  // compares correctly; only the low NNZ_AW bits address the memories.
  logic [NNZ_AW:0]          p;
  logic [NNZ_AW:0]          pend;
  logic [NNZ_AW:0]          ip;
  logic signed [ACC_W-1:0]  acc;
  logic                     zero_q;
  logic                     vld_p1;
  logic                     vld_p2;
  logic signed [DATA_W-1:0] val_p2;

  logic                     load_fire;
  logic [ROW_AW:0]          ptr_raddr;
  logic [NNZ_AW:0]          ptr_rdata;
  logic [DATA_W-1:0]        val_rdata;
  logic [COL_AW-1:0]        col_rdata;
  logic [DATA_W-1:0]        x_rdata;
  logic                     issue;
  logic                     row_empty;
  logic                     last_row;

  assign load_ready = (state == IDLE);
  assign load_fire  = load_valid && load_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign out_valid  = (state == EMIT);
  assign out_row    = r[ROW_AW-1:0];
  assign out_data   = acc;
  assign out_zero   = zero_q;

  assign issue     = (state == WALK) && (ip != pend);
  assign row_empty = (ptr_rdata <= p);
  assign last_row  = ((r + ONE_R) == n_rows_q);

  // The rowptr read for the next row is issued one cycle ahead (in IDLE or
  // EMIT) so both pointers are in hand after the two PTR cycles.
  always_comb begin
    ptr_raddr = r;
    if (state == IDLE) begin
      ptr_raddr = '0;
    end else if ((state == PTR && !ph) || state == EMIT) begin
      ptr_raddr = r + ONE_R;
    end
  end

  spmv_sdp_ram #(.WIDTH(DATA_W), .DEPTH(1 << NNZ_AW), .AW(NNZ_AW)) u_val_ram (
    .clk   (clk),
    .we    (load_fire && (load_sel == SEL_VAL)),
    .waddr (load_addr[NNZ_AW-1:0]),
    .wdata (load_data),
    .raddr (ip[NNZ_AW-1:0]),
    .rdata (val_rdata)
  );

  spmv_sdp_ram #(.WIDTH(COL_AW), .DEPTH(1 << NNZ_AW), .AW(NNZ_AW)) u_col_ram (
    .clk   (clk),
    .we    (load_fire && (load_sel == SEL_COL)),
    .waddr (load_addr[NNZ_AW-1:0]),
    .wdata (load_data[COL_AW-1:0]),
    .raddr (ip[NNZ_AW-1:0]),
    .rdata (col_rdata)
  );

  spmv_sdp_ram #(.WIDTH(NNZ_AW + 1), .DEPTH(PTR_DEPTH), .AW(ROW_AW + 1)) u_ptr_ram (
    .clk   (clk),
    .we    (load_fire && (load_sel == SEL_PTR)),
    .waddr (load_addr[ROW_AW:0]),
    .wdata (load_data[NNZ_AW:0]),
    .raddr (ptr_raddr),
    .rdata (ptr_rdata)
  );

  spmv_sdp_ram #(.WIDTH(DATA_W), .DEPTH(1 << COL_AW), .AW(COL_AW)) u_x_ram (
    .clk   (clk),
    .we    (load_fire && (load_sel == SEL_X)),
    .waddr (load_addr[COL_AW-1:0]),
    .wdata (load_data),
    .raddr (col_rdata),
    .rdata (x_rdata)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (n_rows == '0) ? FIN : PTR;
      PTR:  if (ph) state_nxt = row_empty ? EMIT : WALK;
      // Leave once issue has stopped and only the final product is in
      // flight; it lands in acc on the same edge.
      WALK: if (!issue && !vld_p1) state_nxt = EMIT;
      EMIT: if (out_ready) state_nxt = last_row ? FIN : PTR;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ph       <= 1'b0;
      r        <= '0;
      n_rows_q <= '0;
      p        <= '0;
      pend     <= '0;
      ip       <= '0;
      acc      <= '0;
      zero_q   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_rows_q <= n_rows;
            r        <= '0;
            ph       <= 1'b0;
          end
        end
        PTR: begin
          if (!ph) begin
            p  <= ptr_rdata;
            ph <= 1'b1;
          end else begin
            pend   <= ptr_rdata;
            ip     <= p;
            acc    <= '0;
            zero_q <= row_empty;
            ph     <= 1'b0;
          end
        end
        WALK: begin
          if (issue) ip <= ip + ONE_P;
          if (vld_p2) acc <= acc_add(acc, mul_sext(val_p2, $signed(x_rdata)));
        end
        EMIT: begin
          if (out_ready) r <= r + ONE_R;
        end
        default: ;
      endcase
    end
  end

  // ---- stage 1 -> stage 2: value travels alongside the x lookup ----
  always_ff @(posedge clk) begin
    val_p2 <= $signed(val_rdata);
  end

endmodule

// File: tb/tb_csr_spmv_core.sv
module tb_csr_spmv_core;
  import spmv_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 64;
  localparam int NNZ_AW  = 10;
  localparam int ROW_AW  = 10;
  localparam int COL_AW  = 10;
  localparam int LOAD_AW = 11;

  logic clk = 1'b0;
  logic reset;
  logic load_valid;
  logic load_ready;
  logic [1:0] load_sel;
  logic [LOAD_AW-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic start;
  logic [ROW_AW:0] n_rows;
  logic busy;
  logic done;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [ROW_AW-1:0] out_row;
  logic signed [ACC_W-1:0] out_data;
  logic out_zero;

  always #5 clk = ~clk;

  csr_spmv_core #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NNZ_AW(NNZ_AW), .ROW_AW(ROW_AW), .COL_AW(COL_AW)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .n_rows(n_rows), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_zero(out_zero)
  );

  typedef struct {
    logic                    is_done;
    logic [ROW_AW-1:0]       row;
    logic signed [ACC_W-1:0] data;
    logic                    zero;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   hs_cnt = 0;
  logic bp_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_res(input int row, input logic signed [ACC_W-1:0] data, input logic zero);
    exp_t e;
    e.is_done = 1'b0; e.row = ROW_AW'(row); e.data = data; e.zero = zero;
    expq.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.row = '0; e.data = '0; e.zero = 1'b0;
    expq.push_back(e);
  endtask

  // All main-thread driving happens 1 time unit after a rising edge.
  task automatic load_word(input logic [1:0] sel, input int addr, input logic [31:0] data);
    load_valid = 1'b1; load_sel = sel; load_addr = LOAD_AW'(addr); load_data = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_basic();
    load_word(SEL_VAL, 0, 32'd2);  load_word(SEL_VAL, 1, 32'd1);
    load_word(SEL_VAL, 2, -32'sd3); load_word(SEL_VAL, 3, 32'd4);
    load_word(SEL_COL, 0, 0); load_word(SEL_COL, 1, 2);
    load_word(SEL_COL, 2, 1); load_word(SEL_COL, 3, 2);
    load_word(SEL_PTR, 0, 0); load_word(SEL_PTR, 1, 2);
    load_word(SEL_PTR, 2, 2); load_word(SEL_PTR, 3, 4);
    load_word(SEL_X, 0, 5); load_word(SEL_X, 1, 6); load_word(SEL_X, 2, 7);
  endtask

  task automatic push_basic();
    push_res(0, 64'sd17, 1'b0);
    push_res(1, 64'sd0, 1'b1);
    push_res(2, 64'sd10, 1'b0);
    push_done();
  endtask

  task automatic run_start(input int nr);
    n_rows = (ROW_AW + 1)'(nr); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((expq.size() != 0 || busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    tests++;
    if (c >= budget) begin
      fails++;
      $display("FAIL drain_%s: timeout with %0d results outstanding, required 0", name, expq.size());
      expq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Downstream ready: always 1, or held low 5 cycles per presented result.
  initial begin : ready_driver
    int stall = 0;
    forever begin
      @(posedge clk); #1;
      if (!bp_mode) begin
        out_ready = 1'b1; stall = 0;
      end else if (!out_valid) begin
        out_ready = 1'b0; stall = 0;
      end else if (stall < 5) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = 1'b1; stall = 0;
      end
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin : monitor
    logic stall_prev = 1'b0;
    logic [ROW_AW-1:0] prev_row = '0;
    logic [ACC_W-1:0] prev_data = '0;
    logic prev_zero = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_row", out_row, prev_row);
          check("hold_data", out_data, prev_data);
          check("hold_zero", out_zero, prev_zero);
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (expq.size() == 0 || expq[0].is_done) begin
            tests++; fails++;
            $display("FAIL unexpected_result: row %0d data %0d, required none", out_row, out_data);
          end else begin
            e = expq.pop_front();
            check("res_row", out_row, e.row);
            check("res_data", out_data, e.data);
            check("res_zero", out_zero, e.zero);
          end
        end
        if (done) begin
          if (expq.size() == 0 || !expq[0].is_done) begin
            tests++; fails++;
            $display("FAIL unexpected_done: done=1 with %0d results pending, required none", expq.size());
          end else begin
            e = expq.pop_front();
            check("done_pulse", done, 1);
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_row = out_row; prev_data = out_data; prev_zero = out_zero;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin : main
    int cyc;
    int target;
    reset = 1'b0; load_valid = 1'b0; load_sel = '0; load_addr = '0; load_data = '0;
    start = 1'b0; n_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_load_ready", load_ready, 1);

    // Basic 3x3 with row-0 latency measurement.
    load_basic();
    push_basic();
    n_rows = 11'd3; start = 1'b1; cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 50);
    check("row0_latency_edges", cyc, 7);
    wait_drain("basic", 200);

    // Zero rows: done only.
    push_done();
    run_start(0);
    check("nrows0_done", done, 1);
    check("nrows0_no_valid", out_valid, 0);
    wait_drain("nrows0", 20);

    // Start and load while busy are ignored.
    push_basic();
    run_start(3);
    @(posedge clk); #1;
    start = 1'b1; n_rows = 11'd1;
    load_valid = 1'b1; load_sel = SEL_X; load_addr = '0; load_data = 32'd99;
    check("busy_load_ready", load_ready, 0);
    check("busy_flag", busy, 1);
    @(posedge clk); #1;
    start = 1'b0; load_valid = 1'b0;
    wait_drain("busy_guard", 200);

    // Backpressure: also proves x[0] was not overwritten above.
    bp_mode = 1'b1;
    push_basic();
    run_start(3);
    wait_drain("backpressure", 500);
    bp_mode = 1'b0;
    @(posedge clk); #1;

    // Overflow/sign: 2 * (2^62) wraps to -2^63.
    load_word(SEL_VAL, 10, 32'h8000_0000); load_word(SEL_VAL, 11, 32'h8000_0000);
    load_word(SEL_COL, 10, 8); load_word(SEL_COL, 11, 9);
    load_word(SEL_X, 8, 32'h8000_0000); load_word(SEL_X, 9, 32'h8000_0000);
    load_word(SEL_PTR, 0, 10); load_word(SEL_PTR, 1, 12);
    push_res(0, 64'sh8000_0000_0000_0000, 1'b0); push_done();
    run_start(1);
    wait_drain("overflow", 100);

    // Malformed row: pend < p.
    load_word(SEL_PTR, 0, 3); load_word(SEL_PTR, 1, 1);
    push_res(0, 64'sd0, 1'b1); push_done();
    run_start(1);
    wait_drain("malformed", 100);

    // Boundary row on entries 1022..1023, end pointer equals depth: 7*11 - 9*13 = -40.
    load_word(SEL_VAL, 1022, 32'd7); load_word(SEL_VAL, 1023, -32'sd9);
    load_word(SEL_COL, 1022, 3); load_word(SEL_COL, 1023, 4);
    load_word(SEL_X, 3, 11); load_word(SEL_X, 4, 13);
    load_word(SEL_PTR, 0, 1022); load_word(SEL_PTR, 1, 1024);
    push_res(0, -64'sd40, 1'b0); push_done();
    run_start(1);
    wait_drain("boundary", 100);

    // Non-zeros summing to zero: data 0 but zero flag clear.
    load_word(SEL_VAL, 12, 32'd3); load_word(SEL_VAL, 13, -32'sd3);
    load_word(SEL_COL, 12, 5); load_word(SEL_COL, 13, 6);
    load_word(SEL_X, 5, 4); load_word(SEL_X, 6, 4);
    load_word(SEL_PTR, 0, 12); load_word(SEL_PTR, 1, 14);
    push_res(0, 64'sd0, 1'b0); push_done();
    run_start(1);
    wait_drain("sum_zero", 100);

    // Reset mid-run during the walk of the last row.
    load_word(SEL_PTR, 0, 0); load_word(SEL_PTR, 1, 2);
    push_res(0, 64'sd17, 1'b0); push_res(1, 64'sd0, 1'b1);
    target = hs_cnt + 2;
    run_start(3);
    cyc = 0;
    while (hs_cnt < target && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrun_two_results", hs_cnt, target);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_in_walk_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_zero", out_zero, 0);
    check("arst_out_row", out_row, 0);
    check("arst_out_data", out_data, 0);
    check("arst_queue_empty", expq.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_load_ready", load_ready, 1);

    // Rerun with retained memories.
    push_basic();
    run_start(3);
    wait_drain("rerun", 200);

    check("final_queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
